// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with clear, load, wrap/saturate and tc/ovf flags.
// Optional enable prescaler is compiled in when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int unsigned   PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;

  // Prescaler counts enabled cycles; the counter only steps on its last count.
  always_comb begin
    ps_d = ps_q;
    if (clr || load) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = (ps_q == PsLast) ? '0 : ps_q + 1'b1;
    end
  end

  assign step = en && (ps_q == PsLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step = en;
`endif

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (step) begin
      if (up_dn) begin
        if (at_max) begin
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? MaxVal : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MaxVal;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter = count_q;
  assign ovf     = ovf_q;
  // Terminal count tracks the current direction combinationally.
  assign tc      = up_dn ? at_max : at_zero;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: a wrapping and a saturating instance share stimulus
// and are checked against an arithmetic reference model.
module tb_mod_counter;

  localparam int M = 9;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  mod_counter #(.WIDTH(4), .MAX_COUNT(M), .SATURATE(0), .PRESCALE(P)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .counter(cnt_w), .tc(tc_w), .ovf(ovf_w)
  );

  mod_counter #(.WIDTH(4), .MAX_COUNT(M), .SATURATE(1), .PRESCALE(P)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .counter(cnt_s), .tc(tc_s), .ovf(ovf_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c0; int o0; int t0;
    int c1; int o1; int t1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: index 0 wraps, index 1 saturates.
  int mc[2];
  int mo[2];
  int ps;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int tc_of(int c, logic u);
    return u ? int'(c == M) : int'(c == 0);
  endfunction

  function automatic void model_reset();
    mc[0] = 0; mc[1] = 0; mo[0] = 0; mo[1] = 0; ps = 0;
  endfunction

  function automatic void model_step(logic e, logic u, logic c, logic l, int lv);
    bit tick;
`ifdef MOD_COUNTER_PRESCALE_EN
    tick = 1'b0;
    if (c || l) ps = 0;
    else if (e) begin
      tick = (ps == P - 1);
      ps   = (ps + 1) % P;
    end
`else
    tick = e;
`endif
    for (int s = 0; s < 2; s++) begin
      mo[s] = 0;
      if (c) mc[s] = 0;
      else if (l) mc[s] = (lv > M) ? M : lv;
      else if (tick) begin
        if (u && mc[s] == M) begin
          mo[s] = 1;
          mc[s] = (s == 1) ? M : 0;
        end else if (!u && mc[s] == 0) begin
          mo[s] = 1;
          mc[s] = (s == 1) ? 0 : M;
        end else begin
          mc[s] = u ? (mc[s] + 1) % (M + 1) : (mc[s] + M) % (M + 1);
        end
      end
    end
  endfunction

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input int lv);
    exp_t x;
    en = e; up_dn = u; clr = c; load = l; load_val = 4'(lv);
    @(posedge clk);
    model_step(e, u, c, l, lv);
    x.c0 = mc[0]; x.o0 = mo[0]; x.t0 = tc_of(mc[0], u);
    x.c1 = mc[1]; x.o1 = mo[1]; x.t1 = tc_of(mc[1], u);
    q.push_back(x);
    @(negedge clk);
  endtask

  // Reset asserted between edges must clear outputs before the next clock.
  task automatic async_rst();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_cnt_w", int'(cnt_w), 0);
    chk("arst_ovf_w", int'(ovf_w), 0);
    chk("arst_cnt_s", int'(cnt_s), 0);
    chk("arst_ovf_s", int'(ovf_s), 0);
    chk("arst_tc_w", int'(tc_w), tc_of(0, up_dn));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle with an outstanding expectation is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cnt_wrap", int'(cnt_w), e.c0);
        chk("ovf_wrap", int'(ovf_w), e.o0);
        chk("tc_wrap",  int'(tc_w),  e.t0);
        chk("cnt_sat",  int'(cnt_s), e.c1);
        chk("ovf_sat",  int'(ovf_s), e.o1);
        chk("tc_sat",   int'(tc_s),  e.t1);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cnt", int'(cnt_w), 0);
    chk("rst_ovf", int'(ovf_w), 0);
    chk("rst_tc_down", int'(tc_w), 1);
    chk("rst_cnt_sat", int'(cnt_s), 0);
    rst = 1'b0;

    // Count up through the wrap.
    repeat (12) drive(1, 1, 0, 0, 0);
    // Count down through zero.
    drive(0, 0, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    // Load near the top, saturate, then step back down.
    drive(0, 1, 0, 1, 8);
    repeat (3) drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    // Priority and load clamping.
    drive(1, 1, 1, 1, 5);
    drive(0, 1, 0, 1, 15);
    // Async reset mid-count, then resume.
    drive(0, 1, 1, 0, 0);
    repeat (6) drive(1, 1, 0, 0, 0);
    async_rst();
    repeat (3) drive(1, 1, 0, 0, 0);
    // Prescaler sequence with a clear part way through.
    drive(0, 1, 1, 0, 0);
    repeat (6) drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    repeat (12) drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) async_rst();
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
